tlv5618_rx_decoder: RTL

//  Serial-side receiver/decoder for the TLV5618 3-wire DAC interface (CS_N/SCLK/DIN).

---
 rtl/tlv5618_rx_decoder.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/tlv5618_rx_decoder.sv
// TLV5618 serial receiver/decoder.
// Oversamples CS_N/SCLK/DIN on clk, captures frames MSB first, and applies
// the R1/R0 command semantics to the DAC A, DAC B and buffer registers.
// Edge pulses are registered once after detection, so a decoded frame lands
// SYNC_STAGES+2 clk edges after CS_N is first sampled high.
module tlv5618_rx_decoder #(
    parameter int          SYNC_STAGES = 2,
    parameter int          FRAME_BITS  = 16,
    parameter logic [11:0] RESET_CODE  = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        DAC_CS_N,
    input  logic        DAC_SCLK,
    input  logic        DAC_DIN,
    output logic [15:0] Rx_Word,
    output logic        Word_Valid,
    output logic [11:0] DAC_A,
    output logic [11:0] DAC_B,
    output logic [11:0] DAC_Buf,
    output logic        Speed_Fast,
    output logic        Power_Down,
    output logic        Frame_Err,
    output logic        Rsvd_Err,
    output logic [1:0]  Rx_State
);

    // Counter must hold FRAME_BITS+1 so over-long frames stay distinguishable.
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Bit positions inside the synchroniser vectors.
    localparam int CS_B   = 0;
    localparam int SCLK_B = 1;
    localparam int DIN_B  = 2;

    logic [2:0]       raw_in;
    logic [2:0]       sync_q [SYNC_STAGES];
    logic [2:0]       sync_last;
    logic [1:0]       prev_q;
    logic             cs_fall_q;
    logic             cs_rise_q;
    logic             sclk_fall_q;
    logic             din_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [15:0]      sreg_q, sreg_d;

    logic             frame_ok;
    logic             frame_bad;
    logic [1:0]       r1r0;
    logic [11:0]      data_w;

    logic [15:0]      rx_word_q;
    logic             word_valid_q;
    logic [11:0]      dac_a_q;
    logic [11:0]      dac_b_q;
    logic [11:0]      dac_buf_q;
    logic             speed_fast_q;
    logic             power_down_q;
    logic             frame_err_q;
    logic             rsvd_err_q;

    assign raw_in    = {DAC_DIN, DAC_SCLK, DAC_CS_N};
    assign sync_last = sync_q[SYNC_STAGES-1];

    // First synchroniser stage samples the asynchronous pins. Cleared to 0
    // so a CS_N held low across reset is never seen as a fresh frame start.
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q[0] <= '0;
        else        sync_q[0] <= raw_in;
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            // Remaining synchroniser stages.
            always_ff @(posedge clk) begin
                if (!rst_n) sync_q[gi] <= '0;
                else        sync_q[gi] <= sync_q[gi-1];
            end
        end
    endgenerate

    // Edge detection against one extra register, with registered pulses;
    // DIN is registered alongside so it stays aligned with the SCLK fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q      <= '0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            sclk_fall_q <= 1'b0;
            din_q       <= 1'b0;
        end else begin
            prev_q      <= sync_last[SCLK_B:CS_B];
            cs_fall_q   <= prev_q[CS_B] & ~sync_last[CS_B];
            cs_rise_q   <= ~prev_q[CS_B] & sync_last[CS_B];
            sclk_fall_q <= prev_q[SCLK_B] & ~sync_last[SCLK_B];
            din_q       <= sync_last[DIN_B];
        end
    end

    // FSM state, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= WAIT_IDLE;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sreg_q    <= sreg_d;
        end
    end

    // Next-state logic; a bit arriving together with the CS_N rise is kept.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        case (state_q)
            WAIT_IDLE: begin
                if (sync_last[CS_B]) state_d = IDLE;
            end
            IDLE: begin
                if (cs_fall_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (sclk_fall_q) begin
                    sreg_d = {sreg_q[14:0], din_q};
                    if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (cs_rise_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    assign frame_ok  = (state_q == DONE) && (bit_cnt_q == CNT_FULL);
    assign frame_bad = (state_q == DONE) && (bit_cnt_q != CNT_FULL);
    assign r1r0      = {sreg_q[15], sreg_q[12]};
    assign data_w    = sreg_q[11:0];

    // Command decode into the DAC registers, plus the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_word_q    <= '0;
            word_valid_q <= 1'b0;
            dac_a_q      <= RESET_CODE;
            dac_b_q      <= RESET_CODE;
            dac_buf_q    <= RESET_CODE;
            speed_fast_q <= 1'b0;
            power_down_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rsvd_err_q   <= 1'b0;
        end else begin
            word_valid_q <= frame_ok;
            frame_err_q  <= frame_bad;
            rsvd_err_q   <= frame_ok && (r1r0 == 2'b11);
            if (frame_ok) begin
                rx_word_q <= sreg_q;
                case (r1r0)
                    2'b00: begin
                        dac_b_q   <= data_w;
                        dac_buf_q <= data_w;
                    end
                    2'b01: dac_buf_q <= data_w;
                    2'b10: begin
                        dac_a_q <= data_w;
                        dac_b_q <= dac_buf_q;
                    end
                    default: ;
                endcase
                if (r1r0 != 2'b11) begin
                    speed_fast_q <= sreg_q[14];
                    power_down_q <= sreg_q[13];
                end
            end
        end
    end

    assign Rx_Word    = rx_word_q;
    assign Word_Valid = word_valid_q;
    assign DAC_A      = dac_a_q;
    assign DAC_B      = dac_b_q;
    assign DAC_Buf    = dac_buf_q;
    assign Speed_Fast = speed_fast_q;
    assign Power_Down = power_down_q;
    assign Frame_Err  = frame_err_q;
    assign Rsvd_Err   = rsvd_err_q;
    assign Rx_State   = state_q;

endmodule
